// File: rtl/ram_upload_pkg.sv
// ram_upload_pkg: shared FSM state type, out-of-range word and read tag type for the upload reader
package ram_upload_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE_LO, ISSUE_HI, DRAIN, DONE} state_t;
    localparam logic [15:0] OOR_WORD = 16'hFFFF;
    localparam int TAG_W = 1;
    typedef logic [TAG_W-1:0] tag_t;
    localparam tag_t TAG_LO = 1'b0;
    localparam tag_t TAG_HI = 1'b1;
endpackage

// File: rtl/ram_upload_reader_pipe.sv
// rd_lat_pipe: tracks accepted RAM reads for LAT clocks and strobes capture of the lo/hi byte
module rd_lat_pipe
    import ram_upload_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk_sys,
    input  logic reset_l,
    input  logic flush,
    input  logic push,
    input  tag_t push_tag,
    output logic cap_lo,
    output logic cap_hi
);
    logic [LAT-1:0] vld;
    tag_t [LAT-1:0] tag;
    // shift each accepted read toward the capture stage; a flush empties the pipe
    always_ff @(posedge clk_sys or negedge reset_l) begin
        if (!reset_l) begin
            vld <= '0;
            tag <= '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                vld[i] <= vld[i-1] & ~flush;
                tag[i] <= tag[i-1];
            end
            vld[0] <= push & ~flush;
            tag[0] <= push_tag;
        end
    end
    assign cap_lo = vld[LAT-1] & (tag[LAT-1] == TAG_LO) & ~flush;
    assign cap_hi = vld[LAT-1] & (tag[LAT-1] == TAG_HI) & ~flush;
endmodule

// File: rtl/ram_upload_reader.sv
// ram_upload_reader: serves HPS upload word requests by reading two bytes from a shared RAM port
module ram_upload_reader
    import ram_upload_pkg::*;
#(
    parameter int AW   = 13,
    parameter int SIZE = 8192,
    parameter int LAT  = 1
) (
    input  logic          clk_sys,
    input  logic          reset_l,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [15:0]   ioctl_din,
    output logic          ioctl_wait,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic          mem_gnt,
    input  logic [7:0]    mem_q,
    output logic          busy
);
    state_t        state, state_nx;
    logic [AW-1:0] word_addr;
    logic [15:0]   data;
    logic          start, oor, abort, grant, cap_lo, cap_hi;
    tag_t          push_tag;

    assign start      = ioctl_rd & ioctl_upload & (state == IDLE);
    assign oor        = ioctl_addr >= 25'(SIZE);
    assign abort      = (state != IDLE) & ~ioctl_upload;
    assign grant      = mem_rd & mem_gnt;
    assign busy       = state != IDLE;
    assign ioctl_wait = busy | start;

    rd_lat_pipe #(.LAT(LAT)) u_pipe (
        .clk_sys  (clk_sys),
        .reset_l  (reset_l),
        .flush    (abort),
        .push     (grant),
        .push_tag (push_tag),
        .cap_lo   (cap_lo),
        .cap_hi   (cap_hi)
    );

    // state register
    always_ff @(posedge clk_sys or negedge reset_l) begin
        if (!reset_l)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next state and RAM request; losing ioctl_upload abandons the request from any state
    always_comb begin
        state_nx = state;
        mem_rd   = 1'b0;
        mem_addr = '0;
        push_tag = TAG_LO;
        unique case (state)
            IDLE:     if (start) state_nx = oor ? DONE : ISSUE_LO;
            ISSUE_LO: begin
                mem_rd   = 1'b1;
                mem_addr = word_addr;
                if (mem_gnt) state_nx = ISSUE_HI;
            end
            ISSUE_HI: begin
                mem_rd   = 1'b1;
                mem_addr = {word_addr[AW-1:1], 1'b1};
                push_tag = TAG_HI;
                if (mem_gnt) state_nx = DRAIN;
            end
            DRAIN:    if (cap_hi) state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    // latch the word address, assemble returned bytes and publish the word when leaving DONE
    always_ff @(posedge clk_sys or negedge reset_l) begin
        if (!reset_l) begin
            word_addr <= '0;
            data      <= '0;
            ioctl_din <= '0;
        end else begin
            if (start) word_addr <= {ioctl_addr[AW-1:1], 1'b0};
            if (start && oor) data <= OOR_WORD;
            if (cap_lo) data[7:0] <= mem_q;
            if (cap_hi) data[15:8] <= mem_q;
            if (state == DONE && !abort) ioctl_din <= data;
        end
    end
endmodule

// File: tb/tb_ram_upload_reader.sv
// tb_ram_upload_reader: scoreboard bench running LAT=1 and LAT=3 readers side by side against a RAM model
module tb_ram_upload_reader;
    localparam int AW   = 13;
    localparam int SIZE = 8192;

    typedef struct {
        logic [15:0]   data;
        logic [AW-1:0] addr;
        int            done_cyc;
        bit            exact;
        int            nrd;
    } exp_t;

    logic          clk_sys = 1'b0;
    logic          reset_l = 1'b1;
    logic          ioctl_upload = 1'b1;
    logic          ioctl_rd = 1'b0;
    logic          mem_gnt = 1'b0;
    logic [24:0]   ioctl_addr = '0;
    logic [15:0]   din [2];
    logic          wt [2];
    logic          mrd [2];
    logic          bsy [2];
    logic [AW-1:0] maddr [2];
    logic [7:0]    mq [2];
    logic [7:0]    ram [SIZE];
    logic [7:0]    dl1;
    logic [7:0]    dl3 [3];
    logic [15:0]   mdl [2];
    logic [15:0]   last [2];
    logic          pw [2];
    int            acc [2];
    int            base [2];
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    exp_t          sb [2][$];
    exp_t          cur;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_upload_reader #(.AW(AW), .SIZE(SIZE), .LAT(g == 0 ? 1 : 3)) u_dut (
            .clk_sys      (clk_sys),
            .reset_l      (reset_l),
            .ioctl_upload (ioctl_upload),
            .ioctl_rd     (ioctl_rd),
            .ioctl_addr   (ioctl_addr),
            .ioctl_din    (din[g]),
            .ioctl_wait   (wt[g]),
            .mem_addr     (maddr[g]),
            .mem_rd       (mrd[g]),
            .mem_gnt      (mem_gnt),
            .mem_q        (mq[g]),
            .busy         (bsy[g])
        );
    end

    assign mq[0] = dl1;
    assign mq[1] = dl3[2];

    always #5 clk_sys = ~clk_sys;

    // synchronous RAM model: accepted reads return data LAT clocks later, junk otherwise
    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++)
            if (reset_l && ioctl_upload && mrd[k] && mem_gnt) acc[k] <= acc[k] + 1;
        dl1    <= (mrd[0] && mem_gnt) ? ram[maddr[0]] : 8'($urandom);
        dl3[0] <= (mrd[1] && mem_gnt) ? ram[maddr[1]] : 8'($urandom);
        dl3[1] <= dl3[0];
        dl3[2] <= dl3[1];
    end

    function automatic void chk(input string n, input int k, input bit ok, input int got, input int want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h cyc=%0d", n, k, got, want, cyc);
        end
    endfunction

    function automatic int lat_of(input int k);
        return k == 0 ? 1 : 3;
    endfunction

    function automatic logic [15:0] word_of(input logic [24:0] a);
        int b;
        if (a >= 25'(SIZE)) return 16'hFFFF;
        b = int'({a[AW-1:1], 1'b0});
        return {ram[b+1], ram[b]};
    endfunction

    // monitor: checks reset values, completions against the scoreboard, and quiet behaviour in between
    always begin
        @(negedge clk_sys or negedge reset_l);
        if (!reset_l) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                chk("rst_din", k, din[k] == 16'h0, int'(din[k]), 0);
                chk("rst_wait", k, wt[k] == 1'b0, int'(wt[k]), 0);
                chk("rst_mem_rd", k, mrd[k] == 1'b0, int'(mrd[k]), 0);
                chk("rst_mem_addr", k, maddr[k] == '0, int'(maddr[k]), 0);
                chk("rst_busy", k, bsy[k] == 1'b0, int'(bsy[k]), 0);
                sb[k].delete();
                pw[k]   = 1'b0;
                base[k] = acc[k];
                last[k] = '0;
            end
        end else begin
            #2;
            for (int k = 0; k < 2; k++) begin
                if (pw[k] && !wt[k]) begin
                    chk("done_queued", k, sb[k].size() != 0, sb[k].size(), 1);
                    if (sb[k].size() != 0) begin
                        cur = sb[k].pop_front();
                        chk("din", k, din[k] == cur.data, int'(din[k]), int'(cur.data));
                        chk("latency", k, cur.exact ? cyc == cur.done_cyc : cyc <= cur.done_cyc, cyc, cur.done_cyc);
                        chk("rd_count", k, acc[k] - base[k] == cur.nrd, acc[k] - base[k], cur.nrd);
                        chk("busy_idle", k, bsy[k] == 1'b0, int'(bsy[k]), 0);
                        last[k] = cur.data;
                    end
                    base[k] = acc[k];
                end else begin
                    chk("din_hold", k, din[k] == last[k], int'(din[k]), int'(last[k]));
                    if (sb[k].size() == 0)
                        chk("idle_wait", k, wt[k] == 1'b0, int'(wt[k]), 0);
                    else begin
                        if (mrd[k])
                            chk("mem_addr", k,
                                maddr[k] == (acc[k] == base[k] ? sb[k][0].addr : sb[k][0].addr | 13'd1),
                                int'(maddr[k]), int'(acc[k] == base[k] ? sb[k][0].addr : sb[k][0].addr | 13'd1));
                        chk("deadline", k, cyc <= sb[k][0].done_cyc, cyc, sb[k][0].done_cyc);
                        if (cyc > sb[k][0].done_cyc) begin
                            void'(sb[k].pop_front());
                            base[k] = acc[k];
                        end
                    end
                end
                pw[k] = wt[k];
            end
        end
    end

    // one word request: sl/sh grant stalls in ISSUE_LO/ISSUE_HI, ab>0 drops upload for edge E0+ab
    task automatic do_req(input logic [24:0] a, input int sl, input int sh, input int ab, input bit poke);
        exp_t e;
        int   e0, n;
        bit   o;
        o = a >= 25'(SIZE);
        @(negedge clk_sys);
        e0 = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            e.addr     = {a[AW-1:1], 1'b0};
            e.exact    = !o;
            e.data     = ab > 0 ? mdl[k] : word_of(a);
            e.nrd      = o ? 0 : ab > 0 ? int'(ab > 1 + sl) + int'(ab > 2 + sl + sh) : 2;
            e.done_cyc = e0 + (ab > 0 ? ab : o ? 2 : 3 + lat_of(k) + sl + sh);
            mdl[k]     = e.data;
            sb[k].push_back(e);
        end
        ioctl_addr   = a;
        ioctl_rd     = 1'b1;
        ioctl_upload = 1'b1;
        mem_gnt      = 1'($urandom);
        n = ab > 0 ? ab : 2 + sl + sh;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk_sys);
            ioctl_rd = poke && i == 1;
            mem_gnt  = (i == 1 + sl || i == 2 + sl + sh) ? 1'b1 : i < 2 + sl + sh ? 1'b0 : 1'($urandom);
            if (ab > 0 && i >= ab) ioctl_upload = 1'b0;
        end
        ioctl_rd = 1'b0;
        for (int t = 0; t < 64 && (sb[0].size() != 0 || sb[1].size() != 0); t++) @(negedge clk_sys);
        ioctl_upload = 1'b1;
    endtask

    // request that is cut short by an asynchronous reset while both readers sit in DRAIN
    task automatic reset_in_drain();
        exp_t e;
        @(negedge clk_sys);
        e.addr     = '0;
        e.data     = 16'h0;
        e.exact    = 1'b1;
        e.nrd      = 2;
        e.done_cyc = cyc + 100;
        for (int k = 0; k < 2; k++) sb[k].push_back(e);
        ioctl_addr = '0;
        ioctl_rd   = 1'b1;
        mem_gnt    = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        @(posedge clk_sys);
        @(posedge clk_sys);
        #2 reset_l = 1'b0;
        mdl[0] = '0;
        mdl[1] = '0;
        repeat (2) @(posedge clk_sys);
        #2 reset_l = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) ram[i] = 8'($urandom);
        ram[0]      = 8'h12;
        ram[1]      = 8'h34;
        ram[13'h1FFE] = 8'hAA;
        ram[13'h1FFF] = 8'h55;
        mdl[0] = '0;
        mdl[1] = '0;
        #3 reset_l = 1'b0;
        repeat (3) @(posedge clk_sys);
        #2 reset_l = 1'b1;
        do_req(25'h0, 0, 0, 0, 1'b0);
        do_req(25'h0, 3, 2, 0, 1'b0);
        do_req(25'h2000, 0, 0, 0, 1'b0);
        do_req(25'h1FFE, 0, 0, 0, 1'b0);
        do_req(25'h1FFF, 1, 0, 0, 1'b1);
        do_req(25'h10, 0, 0, 3, 1'b0);
        repeat (6) @(negedge clk_sys);
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b1;
        ioctl_addr   = 25'h4;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        repeat (3) @(negedge clk_sys);
        ioctl_upload = 1'b1;
        reset_in_drain();
        do_req(25'h1, 0, 0, 0, 1'b0);
        for (int r = 0; r < 40; r++)
            do_req($urandom_range(5, 0) == 0 ? 25'($urandom_range(33554431, SIZE)) : 25'($urandom_range(SIZE - 1, 0)),
                   $urandom_range(3, 0), $urandom_range(3, 0), 0, $urandom_range(2, 0) == 0);
        repeat (4) @(negedge clk_sys);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
